// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: request side, UART side and grant status of the TX arbiter.
interface uart_tx_arbiter_if #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8
);
    logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata;
    logic [PORTS-1:0]            s_axis_tvalid;
    logic [PORTS-1:0]            s_axis_tready;
    logic [PORTS-1:0]            s_axis_tlast;
    logic [DATA_WIDTH-1:0]       m_axis_tdata;
    logic                        m_axis_tvalid;
    logic                        m_axis_tready;
    logic [PORTS-1:0]            grant;
    logic                        grant_active;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, grant, grant_active
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, grant, grant_active
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART byte stream, grant held per message or burst.
module uart_tx_arbiter #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 64
) (
    input logic              clk,
    input logic              rst_n,
    uart_tx_arbiter_if.master bus
);
    localparam int IW = $clog2(PORTS);
    localparam int CW = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [CW:0] BURST_LIM = (CW + 1)'(MAX_BURST);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                state, state_nxt;
    logic [PORTS-1:0]      grant_q, grant_nxt, pick_oh;
    logic [IW-1:0]         owner_q, owner_nxt, last_q, last_nxt, pick_idx;
    logic [CW-1:0]         cnt_q, cnt_nxt;
    logic                  pick_found, beat, owner_last, burst_hit, release_now;
    logic [DATA_WIDTH-1:0] mux_data;

    // First requester found searching upward from the port after the last owner
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int i = 0; i < PORTS; i++) begin
            if (!pick_found && bus.s_axis_tvalid[(int'(last_q) + 1 + i) % PORTS]) begin
                pick_found = 1'b1;
                pick_idx   = IW'((int'(last_q) + 1 + i) % PORTS);
            end
        end
        pick_oh = PORTS'(1) << pick_idx;
    end

    // AND-OR data mux gated by the grant so idle or non-owner data never leaks out
    always_comb begin
        mux_data = '0;
        for (int i = 0; i < PORTS; i++)
            mux_data = mux_data | (bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_q[i]}});
    end

    assign bus.m_axis_tdata  = mux_data;
    assign bus.m_axis_tvalid = |(grant_q & bus.s_axis_tvalid);
    assign bus.s_axis_tready = grant_q & {PORTS{bus.m_axis_tready}};
    assign bus.grant         = grant_q;
    assign bus.grant_active  = |grant_q;

    assign beat        = bus.m_axis_tvalid & bus.m_axis_tready;
    assign owner_last  = |(grant_q & bus.s_axis_tlast);
    assign burst_hit   = (MAX_BURST != 0) && (({1'b0, cnt_q} + (CW + 1)'(1)) == BURST_LIM);
    assign release_now = beat & (owner_last | burst_hit);

    // Next state: arbitrate when idle, count beats and release on tlast or full burst when granted
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        owner_nxt = owner_q;
        last_nxt  = last_q;
        cnt_nxt   = cnt_q;
        if (state == IDLE) begin
            if (pick_found) begin
                state_nxt = GRANT;
                grant_nxt = pick_oh;
                owner_nxt = pick_idx;
                cnt_nxt   = '0;
            end
        end else if (release_now) begin
            state_nxt = IDLE;
            grant_nxt = '0;
            cnt_nxt   = '0;
            last_nxt  = owner_q;
        end else if (beat && MAX_BURST != 0 && cnt_q != '1) begin
            cnt_nxt = cnt_q + CW'(1);
        end
    end

    // State registers; reset points the round-robin so port 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= IW'(PORTS - 1);
            cnt_q   <= '0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            owner_q <= owner_nxt;
            last_q  <= last_nxt;
            cnt_q   <= cnt_nxt;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized scoreboard bench for the UART TX arbiter against a queue-based model.
module tb_uart_tx_arbiter;
    localparam int P  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    typedef struct packed {
        logic [P-1:0]  grant;
        logic [P-1:0]  tready;
        logic          mvalid;
        logic [DW-1:0] mdata;
    } cyc_t;

    typedef struct packed {
        logic [P-1:0]  grant;
        logic [DW-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    uart_tx_arbiter_if #(.PORTS(P), .DATA_WIDTH(DW)) bus ();

    uart_tx_arbiter #(.PORTS(P), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    cyc_t        cq[$];
    beat_t       bq[$];
    logic [DW:0] src_q [P][$];
    int vectors = 0, miscompares = 0;
    int own = -1, cnt = 0, lastg = P - 1;
    int gap_pct = 0, rdy_mode = 0, cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit busy();
        bit b = (own >= 0);
        for (int p = 0; p < P; p++) b |= (src_q[p].size() > 0);
        return b;
    endfunction

    // Drive one cycle of stimulus and predict the outputs/beat for it
    task automatic step();
        logic          tv [P];
        logic [DW-1:0] td [P];
        logic [DW:0]   item;
        logic          rdy;
        cyc_t          e;
        beat_t         b;
        cyc++;
        for (int p = 0; p < P; p++) begin
            tv[p] = (src_q[p].size() > 0) && ($urandom_range(99) >= gap_pct);
            td[p] = tv[p] ? src_q[p][0][DW-1:0] : DW'($urandom);
            bus.s_axis_tdata[p*DW +: DW] = td[p];
            bus.s_axis_tvalid[p]         = tv[p];
            bus.s_axis_tlast[p]          = tv[p] ? src_q[p][0][DW] : 1'($urandom);
        end
        rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? cyc[0] : 1'($urandom);
        bus.m_axis_tready = rdy;
        e = '0;
        if (!rst_n) begin
            own = -1; cnt = 0; lastg = P - 1;
        end else if (own >= 0) begin
            e.grant  = P'(1) << own;
            e.tready = rdy ? e.grant : '0;
            e.mvalid = tv[own];
            e.mdata  = td[own];
            if (tv[own] && rdy) begin
                item   = src_q[own].pop_front();
                b.grant = e.grant;
                b.data  = item[DW-1:0];
                bq.push_back(b);
                cnt++;
                if (item[DW] || (MB != 0 && cnt == MB)) begin
                    lastg = own; own = -1; cnt = 0;
                end
            end
        end else begin
            for (int i = 1; i <= P; i++)
                if (tv[(lastg + i) % P]) begin
                    own = (lastg + i) % P;
                    break;
                end
        end
        cq.push_back(e);
    endtask

    task automatic tick(input logic r);
        @(posedge clk);
        #1;
        rst_n = r;
        step();
    endtask

    task automatic cycles(input int n);
        repeat (n) tick(1'b1);
    endtask

    task automatic drain();
        int k = 0;
        while (busy() && k < 3000) begin
            tick(1'b1);
            k++;
        end
        chk("drain_done", 32'(busy()), 0);
        cycles(2);
    endtask

    task automatic do_reset();
        for (int p = 0; p < P; p++) src_q[p].delete();
        tick(1'b0);
        tick(1'b0);
    endtask

    task automatic push_byte(input int p, input logic [DW-1:0] d, input bit l);
        src_q[p].push_back({l, d});
    endtask

    task automatic send(input int p, input int len, input bit term);
        for (int i = 0; i < len; i++) push_byte(p, DW'($urandom), term && (i == len - 1));
    endtask

    // Monitor: compare every cycle's outputs and every accepted byte against the queues
    initial begin
        cyc_t  e;
        beat_t b;
        forever begin
            @(negedge clk);
            if (cq.size() > 0) begin
                e = cq.pop_front();
                chk("grant", 32'(bus.grant), 32'(e.grant));
                chk("grant_active", 32'(bus.grant_active), 32'(|e.grant));
                chk("s_axis_tready", 32'(bus.s_axis_tready), 32'(e.tready));
                chk("m_axis_tvalid", 32'(bus.m_axis_tvalid), 32'(e.mvalid));
                chk("m_axis_tdata", 32'(bus.m_axis_tdata), 32'(e.mdata));
                if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                    chk("beat_expected", 32'(bq.size() > 0), 1);
                    if (bq.size() > 0) begin
                        b = bq.pop_front();
                        chk("beat_data", 32'(bus.m_axis_tdata), 32'(b.data));
                        chk("beat_port", 32'(bus.grant), 32'(b.grant));
                    end
                end
            end
        end
    end

    initial begin
        bus.s_axis_tdata  = '0;
        bus.s_axis_tvalid = '0;
        bus.s_axis_tlast  = '0;
        bus.m_axis_tready = 1'b0;
        tick(1'b0);
        tick(1'b0);
        cycles(2);
        push_byte(2, 8'h41, 1'b0);
        push_byte(2, 8'h42, 1'b1);
        drain();
        do_reset();
        send(0, 3, 1'b1); send(1, 3, 1'b1); send(3, 3, 1'b1); send(0, 2, 1'b1);
        drain();
        do_reset();
        send(1, 10, 1'b1); send(2, 3, 1'b1);
        drain();
        rdy_mode = 1; gap_pct = 30;
        for (int p = 0; p < P; p++) send(p, 3 + p, 1'b1);
        drain();
        rdy_mode = 0; gap_pct = 0;
        send(3, 6, 1'b1);
        cycles(4);
        do_reset();
        send(0, 2, 1'b1); send(3, 2, 1'b1);
        drain();
        for (int i = 0; i < 6; i++) send(0, 1, 1'b1);
        drain();
        rdy_mode = 2; gap_pct = 20;
        for (int i = 0; i < 40; i++) send($urandom_range(P - 1), $urandom_range(1, 7), 1'b1);
        drain();
        @(negedge clk);
        #1;
        chk("beats_left", 32'(bq.size()), 0);
        chk("cycles_left", 32'(cq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
